// File: rtl/seq_booth_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_booth_mult_pkg
// Shared types and defaults for the sequential Booth / shift-add multiplier.
//   state_t     : controller states (S_IDLE, S_ADD, S_SHIFT, S_DONE)
//   booth_op_t  : per-bit accumulator action (none / add / subtract)
//   booth_decode: maps mode and {Q[0], Qm1} to the accumulator action
// Optional build macro used by the multiplier: SEQ_BOOTH_MULT_FAST_SHIFT_EN
// -----------------------------------------------------------------------------
package seq_booth_mult_pkg;

  localparam int DEF_DP_WIDTH = 8;
  localparam int DEF_BC_SIZE  = $clog2(DEF_DP_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_t;

  // Unsigned mode is plain shift-add on Q[0]; signed mode is radix-2 Booth
  // recoding on the bit pair {Q[0], Qm1}.
  function automatic booth_op_t booth_decode(input logic is_sgn,
                                             input logic q0,
                                             input logic qm1);
    booth_op_t op;
    op = OP_NONE;
    if (!is_sgn) begin
      if (q0) op = OP_ADD;
    end else begin
      case ({q0, qm1})
        2'b01:   op = OP_ADD;
        2'b10:   op = OP_SUB;
        default: op = OP_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/seq_booth_mult_if.sv
// -----------------------------------------------------------------------------
// seq_booth_mult_if
// Request/result bundle for seq_booth_mult.
//   start        : request, sampled only while rdy=1
//   is_signed    : 1 = two's-complement Booth, 0 = unsigned shift-add
//   multiplicand : operand B
//   multiplier   : operand Q
//   product      : 2*DP_WIDTH result, valid from done until the next accept
//   rdy          : multiplier idle and able to accept start
//   done         : one-cycle pulse when product becomes valid
// master = requester, slave = multiplier.
// -----------------------------------------------------------------------------
interface seq_booth_mult_if
  import seq_booth_mult_pkg::*;
#(
  parameter int DP_WIDTH = DEF_DP_WIDTH
);

  logic                      start;
  logic                      is_signed;
  logic [DP_WIDTH-1:0]       multiplicand;
  logic [DP_WIDTH-1:0]       multiplier;
  logic [2*DP_WIDTH-1:0]     product;
  logic                      rdy;
  logic                      done;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  product, rdy, done
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output product, rdy, done
  );

endinterface

// File: rtl/seq_booth_mult_addsub.sv
// -----------------------------------------------------------------------------
// seq_booth_mult_addsub
// Combinational (DP_WIDTH+1)-bit accumulator add/subtract.
//   i_a      : accumulator A (DP_WIDTH+1 bits)
//   i_b      : multiplicand B (DP_WIDTH bits)
//   i_signed : 1 = sign-extend B, 0 = zero-extend B
//   i_sub    : 1 = A - ext(B), 0 = A + ext(B)
//   o_sum    : result, modulo 2^(DP_WIDTH+1)
// -----------------------------------------------------------------------------
module seq_booth_mult_addsub #(
  parameter int DP_WIDTH = 8
) (
  input  logic [DP_WIDTH:0]   i_a,
  input  logic [DP_WIDTH-1:0] i_b,
  input  logic                i_signed,
  input  logic                i_sub,
  output logic [DP_WIDTH:0]   o_sum
);

  logic [DP_WIDTH:0] w_b_ext;

  // The extra bit keeps -2^(DP_WIDTH-1) representable after negation and
  // holds the carry out in unsigned mode.
  assign w_b_ext = {(i_signed & i_b[DP_WIDTH-1]), i_b};
  assign o_sum   = i_sub ? (i_a - w_b_ext) : (i_a + w_b_ext);

endmodule

// File: rtl/seq_booth_mult.sv
// -----------------------------------------------------------------------------
// seq_booth_mult
// Sequential multiplier: unsigned shift-add or signed radix-2 Booth, one
// multiplier bit per ADD/SHIFT pair.
//   clk   : clock
//   rst_b : asynchronous active-low reset
//   bus   : seq_booth_mult_if.slave (start, is_signed, multiplicand,
//           multiplier in; product, rdy, done out)
// Default build: fixed latency, done visible in the cycle after edge
// 2*DP_WIDTH counting the accept edge as edge 0.
// Build macro SEQ_BOOTH_MULT_FAST_SHIFT_EN: bits needing no add/subtract are
// shifted directly from S_ADD, latency DP_WIDTH..2*DP_WIDTH.
// -----------------------------------------------------------------------------
module seq_booth_mult
  import seq_booth_mult_pkg::*;
#(
  parameter int DP_WIDTH = DEF_DP_WIDTH,
  parameter int BC_SIZE  = $clog2(DP_WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  seq_booth_mult_if.slave  bus
);

  state_t                r_state;
  logic [DP_WIDTH:0]     r_a;
  logic [DP_WIDTH-1:0]   r_b;
  logic [DP_WIDTH-1:0]   r_q;
  logic                  r_qm1;
  logic [BC_SIZE-1:0]    r_p;
  logic                  r_mode;

  booth_op_t             w_op;
  logic [DP_WIDTH:0]     w_sum;
  logic                  w_shift_msb;
  logic [DP_WIDTH:0]     w_a_sh;
  logic [DP_WIDTH-1:0]   w_q_sh;
  logic [BC_SIZE-1:0]    w_p_dec;
  logic                  w_last;

  assign w_op = booth_decode(r_mode, r_q[0], r_qm1);

  seq_booth_mult_addsub #(
    .DP_WIDTH (DP_WIDTH)
  ) u_addsub (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_signed (r_mode),
    .i_sub    (w_op == OP_SUB),
    .o_sum    (w_sum)
  );

  // Right shift of {A, Q, Qm1}: logical in unsigned mode, arithmetic in
  // signed mode. Qm1 picks up Q[0] directly in the sequential block.
  assign w_shift_msb = r_mode & r_a[DP_WIDTH];
  assign w_a_sh      = {w_shift_msb, r_a[DP_WIDTH:1]};
  assign w_q_sh      = {r_a[0], r_q[DP_WIDTH-1:1]};
  assign w_p_dec     = r_p - BC_SIZE'(1);
  assign w_last      = (w_p_dec == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_p     <= BC_SIZE'(DP_WIDTH);
      r_mode  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= '0;
            r_b     <= bus.multiplicand;
            r_q     <= bus.multiplier;
            r_qm1   <= 1'b0;
            r_p     <= BC_SIZE'(DP_WIDTH);
            r_mode  <= bus.is_signed;
            r_state <= S_ADD;
          end
        end

        S_ADD: begin
`ifdef SEQ_BOOTH_MULT_FAST_SHIFT_EN
          if (w_op == OP_NONE) begin
            // Nothing to accumulate for this bit: shift right away.
            r_a     <= w_a_sh;
            r_q     <= w_q_sh;
            r_qm1   <= r_q[0];
            r_p     <= w_p_dec;
            r_state <= w_last ? S_DONE : S_ADD;
          end else begin
            r_a     <= w_sum;
            r_state <= S_SHIFT;
          end
`else
          if (w_op != OP_NONE) begin
            r_a <= w_sum;
          end
          r_state <= S_SHIFT;
`endif
        end

        S_SHIFT: begin
          r_a     <= w_a_sh;
          r_q     <= w_q_sh;
          r_qm1   <= r_q[0];
          r_p     <= w_p_dec;
          r_state <= w_last ? S_DONE : S_ADD;
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A and Q are untouched in S_DONE and S_IDLE, so the product holds until
  // the next accepted start reloads them.
  assign bus.product = {r_a[DP_WIDTH-1:0], r_q};
  assign bus.rdy     = (r_state == S_IDLE);
  assign bus.done    = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_booth_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_booth_mult
// Directed self-checking bench for seq_booth_mult at DP_WIDTH=8.
// Honours SEQ_BOOTH_MULT_FAST_SHIFT_EN for the expected latencies.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_booth_mult;

`ifdef SEQ_BOOTH_MULT_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int FIXED_LAT = 16;

  logic clk;
  logic rst_b;

  seq_booth_mult_if #(.DP_WIDTH(8)) bus ();

  seq_booth_mult #(.DP_WIDTH(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        sgn;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [15:0] prod;
    int          lat_fast;
  } vec_t;

  vec_t vecs [7];

  // Issue one multiply from idle and wait (bounded) for done.
  // lat = number of edges after the accept edge when done is first seen.
  task automatic run_op(input logic sgn, input logic [7:0] b,
                        input logic [7:0] q, output int lat,
                        output logic [15:0] res);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.is_signed    = sgn;
    bus.multiplicand = b;
    bus.multiplier   = q;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    res = 16'hxxxx;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        res = bus.product;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [15:0] res;
    logic        rdy_bad;
    logic        done_bad;
    int          t1, t2;
    logic [15:0] res1, res2;

    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 16};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, 9};
    vecs[2] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF, 10};
    vecs[3] = '{1'b1, 8'h7F, 8'h80, 16'hC080, 9};
    vecs[4] = '{1'b0, 8'hA5, 8'h00, 16'h0000, 8};  // zero multiplier
    vecs[5] = '{1'b1, 8'h05, 8'hFD, 16'hFFF1, 11};
    vecs[6] = '{1'b0, 8'h0C, 8'h0A, 16'h0078, 10};

    bus.start        = 1'b0;
    bus.is_signed    = 1'b0;
    bus.multiplicand = 8'h00;
    bus.multiplier   = 8'h00;
    rst_b            = 1'b0;

    // Reset state
    #12;
    check_val("rst_rdy",  {31'd0, bus.rdy},  32'd1);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_prod", {16'd0, bus.product}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      check_val($sformatf("v%0d_rdy", i), {31'd0, bus.rdy}, 32'd1);
      run_op(vecs[i].sgn, vecs[i].b, vecs[i].q, lat, res);
      $display("txn v%0d: sgn=%0d b=0x%02h q=0x%02h -> product=0x%04h lat=%0d",
               i, vecs[i].sgn, vecs[i].b, vecs[i].q, res, lat);
      check_val($sformatf("v%0d_prod", i), {16'd0, res}, {16'd0, vecs[i].prod});
      check_val($sformatf("v%0d_lat", i), lat,
                FAST ? vecs[i].lat_fast : FIXED_LAT);
      // Product must hold through the following idle cycle
      @(negedge clk);
      check_val($sformatf("v%0d_hold", i), {16'd0, bus.product},
                {16'd0, vecs[i].prod});
    end

    // Start pulsed mid-operation must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0;
    bus.multiplicand = 8'h0C; bus.multiplier = 8'h0A;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; res = 16'hxxxx; rdy_bad = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) begin
        bus.start = 1'b1; bus.is_signed = 1'b1;
        bus.multiplicand = 8'h07; bus.multiplier = 8'h07;
      end
      if (k == 5) bus.start = 1'b0;
      if (bus.rdy) rdy_bad = 1'b1;
      if (bus.done) begin
        lat = k; res = bus.product;
        break;
      end
    end
    $display("txn midstart: product=0x%04h lat=%0d rdy_seen=%0d", res, lat, rdy_bad);
    check_val("mid_prod", {16'd0, res}, 32'h0078);
    check_val("mid_lat", lat, FAST ? 10 : FIXED_LAT);
    check_val("mid_rdy_low", {31'd0, rdy_bad}, 32'd0);
    @(negedge clk);
    check_val("mid_rdy_after", {31'd0, bus.rdy}, 32'd1);
    check_val("mid_prod_after", {16'd0, bus.product}, 32'h0078);

    // Reset asserted in cycle 5 of a multiply
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0;
    bus.multiplicand = 8'hC8; bus.multiplier = 8'h64;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    done_bad = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) done_bad = 1'b1;
    end
    rst_b = 1'b0;
    #1;
    check_val("ar_prod", {16'd0, bus.product}, 32'd0);
    check_val("ar_rdy",  {31'd0, bus.rdy},  32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done) done_bad = 1'b1;
    end
    rst_b = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) done_bad = 1'b1;
    end
    $display("txn reset_abort: done_seen=%0d", done_bad);
    check_val("ar_no_done", {31'd0, done_bad}, 32'd0);
    run_op(1'b0, 8'h03, 8'h05, lat, res);
    $display("txn after_reset: 3 x 5 -> product=0x%04h lat=%0d", res, lat);
    check_val("ar_next_prod", {16'd0, res}, 32'h000F);
    check_val("ar_next_lat", lat, FAST ? 10 : FIXED_LAT);

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0;
    bus.multiplicand = 8'hFF; bus.multiplier = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.multiplicand = 8'h10; bus.multiplier = 8'hFF;
    t1 = -1; t2 = -1; res1 = 16'hxxxx; res2 = 16'hxxxx;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        if (t1 < 0) begin
          t1 = k; res1 = bus.product;
        end else begin
          t2 = k; res2 = bus.product;
          break;
        end
      end
    end
    bus.start = 1'b0;
    $display("txn b2b: first=0x%04h @%0d second=0x%04h @%0d", res1, t1, res2, t2);
    check_val("b2b_prod1", {16'd0, res1}, 32'hFE01);
    check_val("b2b_prod2", {16'd0, res2}, 32'h0FF0);
    check_val("b2b_t1", t1, 16);
    check_val("b2b_gap", (t1 < 0 || t2 < 0) ? -1 : (t2 - t1), 18);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
